bar_sprite_writer: RTL
======================

# bar_sprite_writer

Write-side controller for the bar sprite RAM. It accepts pixel-write, rectangle-fill and clear commands over a valid/ready handshake. It drives the RAM's `we`/`addr_w`/`din` port at one pixel per cycle, so the bar bitmap can be redrawn at run time while the renderer keeps reading through `addr_r`/`dout`. It sits between the bus-side register slot and the bar sprite RAM.

## Interface
- `ADDR_WIDTH`, 10: RAM address bits; must match the RAM.
- `DATA_WIDTH`, 10: pixel colour bits; must match the RAM.
- `X_WIDTH`, 5: column bits. Sprite row length is `2**X_WIDTH`. Row bits `Y_WIDTH = ADDR_WIDTH - X_WIDTH`.
- `CLEAR_COLOR`, 10'h000: colour written by the clear command (transparent key).
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: 00 single pixel, 01 rectangle fill, 10 clear all, 11 no-op.
- `cmd_x0` in X_WIDTH: start column.
- `cmd_y0` in Y_WIDTH: start row.
- `cmd_w` in X_WIDTH+1: rectangle width in pixels.
- `cmd_h` in Y_WIDTH+1: rectangle height in pixels.
- `cmd_color` in DATA_WIDTH: pixel colour.
- `we` out 1: RAM write enable.
- `addr_w` out ADDR_WIDTH: RAM write address, `{y, x}`.
- `din` out DATA_WIDTH: RAM write data.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- States are IDLE, WRITE and DONE.
- `cmd_ready = (state == IDLE)`. A command is accepted on any edge where `cmd_valid && cmd_ready`. All `cmd_*` fields are captured on acceptance; later changes are ignored.
- IDLE → WRITE on acceptance when the effective pixel count is greater than 0.
- IDLE → DONE on acceptance when the count is 0, or when `cmd_op` = 11.
- WRITE → DONE after the last pixel is written. DONE → IDLE unconditionally.
- Single pixel is treated as a 1×1 fill at (`x0`, `y0`).
- Rectangle fill:
  - Iterates in raster order: x from `x0` upward within a row, then y increments and x returns to `x0`.
  - Effective size is `w_eff × h_eff`, fixed at acceptance (see Configuration).
- Clear all writes `CLEAR_COLOR` to every address from 0 to `2**ADDR_WIDTH-1` in ascending order. `cmd_x0`, `cmd_y0`, `cmd_w`, `cmd_h` and `cmd_color` are ignored.
- `w = 0` or `h = 0` (or an effective size of 0) produces no writes; `done` still pulses.
- `addr_w = y*2**X_WIDTH + x`. Iterator arithmetic is X_WIDTH+1 / Y_WIDTH+1 bits wide. The end test compares the pixel count, never a wrapped coordinate.
- A `reset_n` low in the middle of a command returns the block to IDLE and stops writes immediately. Pixels already written stay in the RAM. No `done` is generated.

## Timing
- Reset values: `cmd_ready` = 1, `we` = 0, `addr_w` = 0, `din` = 0, `busy` = 0, `done` = 0. State is IDLE.
- All outputs are registered.
- If a command is accepted at edge 0, the first `we` is high in the cycle after edge 0.
- N effective pixels produce exactly N consecutive `we` cycles with no gaps.
- `done` is high for one cycle immediately after the last `we` cycle. `cmd_ready` returns high the cycle after that.
- With N = 0, `done` is high in the cycle after acceptance.
- `busy` is high from the cycle after acceptance through the `done` cycle inclusive. It is the complement of `cmd_ready`.
- Command-to-command throughput is N+2 cycles.
- `we` is never high while `cmd_ready` is high.
- The renderer may read the RAM concurrently. A same-address read during a write returns old data, per the RAM's read-before-write behaviour.

## Configuration
- `BAR_WRITER_CLIP_EN` defined:
  - `w_eff = min(w, 2**X_WIDTH - x0)`.
  - `h_eff = min(h, 2**Y_WIDTH - y0)`.
  - The rectangle is clipped at the right and bottom edges; nothing wraps.
- `BAR_WRITER_CLIP_EN` undefined:
  - `w_eff = min(w, 2**X_WIDTH)` and `h_eff = min(h, 2**Y_WIDTH)`.
  - x and y wrap modulo the sprite dimensions, so pixels past an edge land on column 0 / row 0.

## Test plan
- Reset, then a single pixel at (3, 2) with colour 10'h155 → one `we` cycle with `addr_w` = 67 and `din` = 10'h155, then `done` the next cycle, then `cmd_ready` the cycle after.
- Fill x0=4, y0=1, w=3, h=2, colour 10'h3FF → six writes to addresses 36, 37, 38, 68, 69, 70 on consecutive cycles. `busy` is high for 7 cycles.
- Fill x0=30, y0=31, w=4, h=3:
  - With `BAR_WRITER_CLIP_EN`: writes to 1022 and 1023 only.
  - Without it: writes to 1022, 1023, 992, 993, 30, 31, 0, 1, then 62, 63, 32, 33.
- Clear all → 1024 writes of `CLEAR_COLOR` to addresses 0..1023 in order. `done` occurs at cycle 1025 after acceptance.
- Fill with w=0, then op 11 → no `we` in either case. `done` arrives 1 cycle after each acceptance. `cmd_valid` held high throughout is accepted only when `cmd_ready` is high.
- `reset_n` low for one edge in the middle of a clear (after 100 writes) → `we` is 0 on the next cycle, no `done`, `cmd_ready` = 1. A new single-pixel command then completes normally.

Source files
------------

// File: rtl/bar_sprite_writer.sv
`timescale 1ns/1ps
// bar_sprite_writer: write-side controller for the bar sprite RAM.
// Accepts single-pixel, rectangle-fill, clear and no-op commands over a
// valid/ready handshake and streams one RAM write per cycle in raster order.
// Optional feature macro: BAR_WRITER_CLIP_EN (clip rectangles at the right
// and bottom edges instead of wrapping around the sprite).
module bar_sprite_writer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 10,
    parameter int X_WIDTH    = 5,
    parameter logic [DATA_WIDTH-1:0] CLEAR_COLOR = '0,
    localparam int Y_WIDTH   = ADDR_WIDTH - X_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [X_WIDTH-1:0]    cmd_x0,
    input  logic [Y_WIDTH-1:0]    cmd_y0,
    input  logic [X_WIDTH:0]      cmd_w,
    input  logic [Y_WIDTH:0]      cmd_h,
    input  logic [DATA_WIDTH-1:0] cmd_color,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    localparam logic [X_WIDTH:0] X_ONE  = {{X_WIDTH{1'b0}}, 1'b1};
    localparam logic [Y_WIDTH:0] Y_ONE  = {{Y_WIDTH{1'b0}}, 1'b1};
    localparam logic [X_WIDTH:0] FULL_W = {1'b1, {X_WIDTH{1'b0}}};
    localparam logic [Y_WIDTH:0] FULL_H = {1'b1, {Y_WIDTH{1'b0}}};

    state_t state_reg, state_next;

    // Captured command (effective rectangle), and raster position counters
    logic [X_WIDTH-1:0]    x0_reg;
    logic [Y_WIDTH-1:0]    y0_reg;
    logic [X_WIDTH:0]      w_eff_reg;
    logic [Y_WIDTH:0]      h_eff_reg;
    logic [DATA_WIDTH-1:0] color_reg;
    logic [X_WIDTH:0]      col_reg;
    logic [Y_WIDTH:0]      row_reg;

    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] din_reg;
    logic                  ready_reg;
    logic                  busy_reg;
    logic                  done_reg;

    // Decoded command fields before capture
    logic [X_WIDTH-1:0]    sel_x0;
    logic [Y_WIDTH-1:0]    sel_y0;
    logic [X_WIDTH:0]      sel_w;
    logic [Y_WIDTH:0]      sel_h;
    logic [DATA_WIDTH-1:0] sel_color;
    logic                  sel_nop;
    logic [X_WIDTH:0]      sel_w_eff;
    logic [Y_WIDTH:0]      sel_h_eff;
    logic                  sel_empty;

    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    logic [X_WIDTH:0]      col_next;
    logic [Y_WIDTH:0]      row_next;
    logic [X_WIDTH-1:0]    x_next;
    logic [Y_WIDTH-1:0]    y_next;

    assign cmd_ready = ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign we        = we_reg;
    assign addr_w    = addr_reg;
    assign din       = din_reg;

    assign accept = cmd_valid && (state_reg == S_IDLE);

    // Map every opcode onto a rectangle fill and compute its effective size
    always_comb begin
        sel_x0    = cmd_x0;
        sel_y0    = cmd_y0;
        sel_w     = cmd_w;
        sel_h     = cmd_h;
        sel_color = cmd_color;
        sel_nop   = 1'b0;
        case (cmd_op)
            2'b00: begin
                sel_w = X_ONE;
                sel_h = Y_ONE;
            end
            2'b01: begin
            end
            2'b10: begin
                sel_x0    = '0;
                sel_y0    = '0;
                sel_w     = FULL_W;
                sel_h     = FULL_H;
                sel_color = CLEAR_COLOR;
            end
            default: sel_nop = 1'b1;
        endcase
`ifdef BAR_WRITER_CLIP_EN
        // Remaining columns/rows to the edge are never zero, so a clipped
        // rectangle is empty only if the requested size is.
        if (sel_w < (FULL_W - {1'b0, sel_x0}))
            sel_w_eff = sel_w;
        else
            sel_w_eff = FULL_W - {1'b0, sel_x0};
        if (sel_h < (FULL_H - {1'b0, sel_y0}))
            sel_h_eff = sel_h;
        else
            sel_h_eff = FULL_H - {1'b0, sel_y0};
`else
        sel_w_eff = (sel_w > FULL_W) ? FULL_W : sel_w;
        sel_h_eff = (sel_h > FULL_H) ? FULL_H : sel_h;
`endif
        sel_empty = sel_nop || (sel_w_eff == '0) || (sel_h_eff == '0);
    end

    // Raster advance: next column/row index and the wrapped coordinates
    always_comb begin
        col_last = ((col_reg + X_ONE) == w_eff_reg);
        row_last = ((row_reg + Y_ONE) == h_eff_reg);
        col_next = col_reg + X_ONE;
        row_next = row_reg;
        if (col_last) begin
            col_next = '0;
            row_next = row_reg + Y_ONE;
        end
        // Index is always below the effective size, so the low bits suffice;
        // truncation of the sum gives the wrap-around behaviour.
        x_next = x0_reg + col_next[X_WIDTH-1:0];
        y_next = y0_reg + row_next[Y_WIDTH-1:0];
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept)
                    state_next = sel_empty ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                if (col_last && row_last)
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Command capture, pixel stream and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x0_reg    <= '0;
            y0_reg    <= '0;
            w_eff_reg <= '0;
            h_eff_reg <= '0;
            color_reg <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            din_reg   <= '0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            ready_reg <= (state_next == S_IDLE);
            busy_reg  <= (state_next != S_IDLE);
            done_reg  <= (state_next == S_DONE);
            case (state_reg)
                S_IDLE: begin
                    we_reg <= 1'b0;
                    if (accept) begin
                        x0_reg    <= sel_x0;
                        y0_reg    <= sel_y0;
                        w_eff_reg <= sel_w_eff;
                        h_eff_reg <= sel_h_eff;
                        color_reg <= sel_color;
                        col_reg   <= '0;
                        row_reg   <= '0;
                        if (!sel_empty) begin
                            we_reg   <= 1'b1;
                            addr_reg <= {sel_y0, sel_x0};
                            din_reg  <= sel_color;
                        end
                    end
                end
                S_WRITE: begin
                    if (col_last && row_last) begin
                        we_reg <= 1'b0;
                    end else begin
                        we_reg   <= 1'b1;
                        col_reg  <= col_next;
                        row_reg  <= row_next;
                        addr_reg <= {y_next, x_next};
                        din_reg  <= color_reg;
                    end
                end
                default: we_reg <= 1'b0;
            endcase
        end
    end

endmodule
